ov5642_video_rx: RTL and testbench

Receive-side front end for the OV5642 8-bit parallel DVP camera bus. Samples `din`/`href`/`vsync` on the camera pixel clock and produces a byte-level stream with line-end marking. It then packs byte pairs into 16-bit (RGB565/YUV422) pixel beats with `tlast` at end of line. It sits between the sensor pins and the downstream video DMA/FIFO. There is no backpressure, because the sensor cannot be stalled.

---
 rtl/ov5642_rx_pkg.sv | 21 ++
 rtl/ov5642_video_rx_if.sv | 20 ++
 rtl/ov5642_pixel_packer.sv | 97 +++++++++
 rtl/ov5642_video_rx.sv | 50 +++++
 tb/tb_ov5642_video_rx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov5642_rx_pkg.sv
// Shared constants and the byte-beat type for the OV5642 DVP receiver.
// Build option: OV5642_RX_SOF_EN adds the start-of-frame flag and m_tuser.
package ov5642_rx_pkg;

   localparam int BYTE_W = 8;
   localparam int PIX_W  = 16;

   // Pad byte placed in the low half of the final pixel of an odd-length line
   localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

   // Packer phase: which half of the pixel the next byte fills
   localparam logic [0:0] PH_HIGH = 1'b0;
   localparam logic [0:0] PH_LOW  = 1'b1;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              valid;
      logic              last;
   } byte_beat_t;

endpackage

// File: rtl/ov5642_video_rx_if.sv
// Pixel stream leaving the receiver. There is no ready: m_tvalid is a one-cycle
// pulse the sink must accept, m_tlast/m_tuser/m_tdata are 0 whenever m_tvalid is 0.
interface ov5642_video_rx_if
   import ov5642_rx_pkg::*;
   ();

   logic [PIX_W-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
`ifdef OV5642_RX_SOF_EN
   logic             m_tuser;

   modport master (output m_tdata, output m_tvalid, output m_tlast, output m_tuser);
   modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, input  m_tuser);
`else
   modport master (output m_tdata, output m_tvalid, output m_tlast);
   modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast);
`endif

endinterface

// File: rtl/ov5642_pixel_packer.sv
// Packs consecutive line bytes into 16-bit pixels, padding odd-length lines.
// Build option: OV5642_RX_SOF_EN adds the SOF-pending flag driving m_tuser.
module ov5642_pixel_packer
   import ov5642_rx_pkg::*;
(
   input  logic                pclk,
   input  logic                rst_n,
   input  logic                vsync,
   input  byte_beat_t          beat_i,
   ov5642_video_rx_if.master   m
);

   logic [0:0]        phase_q, phase_d;
   logic [BYTE_W-1:0] hold_q, hold_d;
   logic [PIX_W-1:0]  tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;

   // A valid beat always wins over vsync: the tail of a line cut short by
   // vsync is still in flight when vsync is already high and must be emitted.
   always_comb begin
      phase_d  = phase_q;
      hold_d   = hold_q;
      tdata_d  = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      if (beat_i.valid) begin
         if (phase_q == PH_HIGH) begin
            if (beat_i.last) begin
               tvalid_d = 1'b1;
               tdata_d  = {beat_i.data, PAD_BYTE};
               tlast_d  = 1'b1;
            end else begin
               hold_d  = beat_i.data;
               phase_d = PH_LOW;
            end
         end else begin
            tvalid_d = 1'b1;
            tdata_d  = {hold_q, beat_i.data};
            tlast_d  = beat_i.last;
            phase_d  = PH_HIGH;
         end
      end else if (vsync) begin
         phase_d = PH_HIGH;
         hold_d  = '0;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= PH_HIGH;
         hold_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         hold_q   <= hold_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign m.m_tdata  = tdata_q;
   assign m.m_tvalid = tvalid_q;
   assign m.m_tlast  = tlast_q;

`ifdef OV5642_RX_SOF_EN
   logic sof_pend_q, sof_pend_d;
   logic tuser_q, tuser_d;

   // Pixels still draining while vsync is high belong to the old frame.
   always_comb begin
      sof_pend_d = sof_pend_q;
      tuser_d    = tvalid_d & sof_pend_q & ~vsync;
      if (vsync) begin
         sof_pend_d = 1'b1;
      end else if (tvalid_d) begin
         sof_pend_d = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         sof_pend_q <= 1'b1;
         tuser_q    <= 1'b0;
      end else begin
         sof_pend_q <= sof_pend_d;
         tuser_q    <= tuser_d;
      end
   end

   assign m.m_tuser = tuser_q;
`endif

endmodule

// File: rtl/ov5642_video_rx.sv
// OV5642 DVP receive front end: two-stage pin capture into byte beats, then pixel packing.
// Build option: OV5642_RX_SOF_EN enables the m_tuser start-of-frame marker.
module ov5642_video_rx
   import ov5642_rx_pkg::*;
(
   input  logic              pclk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] din,
   input  logic              href,
   input  logic              vsync,
   ov5642_video_rx_if.master m
);

   logic [BYTE_W-1:0] d_a_q;
   logic              h_a_q;
   logic              armed_q;
   byte_beat_t        beat_q;
   logic              line_raw;
   logic              line_qual;

   // After reset, wait for href to drop so a line already in progress is not
   // picked up half way through with its bytes in the wrong pixel halves.
   assign line_raw  = href & ~vsync;
   assign line_qual = line_raw & armed_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         d_a_q   <= '0;
         h_a_q   <= 1'b0;
         armed_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         d_a_q       <= din;
         h_a_q       <= line_qual;
         armed_q     <= armed_q | ~line_raw;
         beat_q.data  <= d_a_q;
         beat_q.valid <= h_a_q;
         beat_q.last  <= h_a_q & ~line_qual;
      end
   end

   ov5642_pixel_packer u_packer (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .vsync  (vsync),
      .beat_i (beat_q),
      .m      (m)
   );

endmodule

// File: tb/tb_ov5642_video_rx.sv
// Self-checking bench for ov5642_video_rx: directed scenarios plus random lines
// against a line-level reference model. Build option: OV5642_RX_SOF_EN.
module tb_ov5642_video_rx;
   import ov5642_rx_pkg::*;

   // expected word: {emit edge[31:0], tuser, tlast, tdata[15:0]}
   localparam int EXP_W   = 50;
   localparam int NO_VS   = 32'h3fff_ffff;

   typedef logic [7:0] bq_t[$];

   logic       pclk  = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din   = 8'h00;
   logic       href  = 1'b0;
   logic       vsync = 1'b0;

   ov5642_video_rx_if bus ();

   ov5642_video_rx dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .din   (din),
      .href  (href),
      .vsync (vsync),
      .m     (bus)
   );

   // ---------------- clock / reset block ----------------
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   logic tuser_obs;
`ifdef OV5642_RX_SOF_EN
   assign tuser_obs = bus.m_tuser;
`else
   assign tuser_obs = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  sof_m = 1'b1;
   bit  chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Line-level model: bytes pair up in order, an odd tail is padded with 00,
   // the final pixel carries tlast, and a pixel lands 3 edges after the drive
   // edge of its last byte. Pixels landing while vsync is high never carry SOF.
   task automatic push_line(input bq_t b, input int start, input int vs_edge);
      int          n;
      logic [15:0] data;
      logic        last;
      logic        user;
      int          pe;
      n = b.size();
      for (int i = 0; i < n; i += 2) begin
         if (i + 1 < n) begin
            data = {b[i], b[i+1]};
            pe   = start + i + 1 + 3;
            last = (i + 2 >= n);
         end else begin
            data = {b[i], 8'h00};
            pe   = start + i + 3;
            last = 1'b1;
         end
`ifdef OV5642_RX_SOF_EN
         if (pe > vs_edge) begin
            user = 1'b0;
         end else begin
            user  = sof_m;
            sof_m = 1'b0;
         end
`else
         user = 1'b0;
`endif
         exp_q.push_back({pe[31:0], user, last, data});
      end
   endtask

   logic [EXP_W-1:0] mon_e;
   always @(negedge pclk) begin
      if (rst_n && chk_en) begin
         if (bus.m_tvalid) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_bad++;
               $error("FAIL unexpected_pixel observed=%h expected=none", bus.m_tdata);
            end
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               n_cmp++;
               assert (bus.m_tdata === mon_e[15:0]) else begin
                  n_bad++;
                  $error("FAIL pix_data observed=%h expected=%h", bus.m_tdata, mon_e[15:0]);
               end
               n_cmp++;
               assert (bus.m_tlast === mon_e[16]) else begin
                  n_bad++;
                  $error("FAIL pix_last data=%h observed=%b expected=%b", mon_e[15:0], bus.m_tlast, mon_e[16]);
               end
               n_cmp++;
               assert (tuser_obs === mon_e[17]) else begin
                  n_bad++;
                  $error("FAIL pix_user data=%h observed=%b expected=%b", mon_e[15:0], tuser_obs, mon_e[17]);
               end
               n_cmp++;
               assert (cyc === int'(mon_e[49:18])) else begin
                  n_bad++;
                  $error("FAIL pix_time data=%h observed=%0d expected=%0d", mon_e[15:0], cyc, mon_e[49:18]);
               end
            end
         end else begin
            n_cmp++;
            assert ({bus.m_tdata, bus.m_tlast, tuser_obs} === 18'h0) else begin
               n_bad++;
               $error("FAIL idle_zero observed=%h expected=0", {bus.m_tdata, bus.m_tlast, tuser_obs});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         href  = 1'b0;
         vsync = 1'b0;
         din   = 8'($urandom);
      end
   endtask

   task automatic send_bytes(input bq_t b, input bit abort, input int gap);
      int start;
      int n;
      n     = b.size();
      start = cyc + 1;
      push_line(b, start, abort ? start + n : NO_VS);
      for (int i = 0; i < n; i++) begin
         tick();
         din   = b[i];
         href  = 1'b1;
         vsync = 1'b0;
      end
      if (abort) begin
         for (int k = 0; k < int'($urandom_range(4, 10)); k++) begin
            tick();
            vsync = 1'b1;
            href  = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
         end
         sof_m = 1'b1;
      end
      idle(gap);
   endtask

   task automatic send_rand(input int n, input bit abort, input int gap);
      bq_t b;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
      send_bytes(b, abort, gap);
   endtask

   task automatic vsync_pulse(input int n);
      idle(4);
      for (int k = 0; k < n; k++) begin
         tick();
         vsync = 1'b1;
         href  = 1'($urandom_range(0, 1));
         din   = 8'($urandom);
      end
      sof_m = 1'b1;
      idle(1);
   endtask

   task automatic drain(input string tag);
      idle(8);
      chk(tag, exp_q.size(), 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bq_t b;
      logic [7:0] r0, r1;

      // reset state
      idle(3);
      chk("rst_tvalid", 32'(bus.m_tvalid), 0);
      chk("rst_tdata",  32'(bus.m_tdata), 0);
      chk("rst_tlast",  32'(bus.m_tlast), 0);
      chk("rst_tuser",  32'(tuser_obs), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      idle(3);

      // even line 0x10..0x19
      b = {};
      for (int i = 0; i < 10; i++) b.push_back(8'(8'h10 + i));
      send_bytes(b, 1'b0, 10);
      drain("even_line_done");

      // two lines separated by a gap
      send_rand(10, 1'b0, 10);
      send_rand(10, 1'b0, 10);
      drain("two_lines_done");

      // odd line, single-cycle gap, then an even line starting at phase 0
      b = {8'hAA, 8'hBB, 8'hCC};
      send_bytes(b, 1'b0, 1);
      send_rand(4, 1'b0, 3);
      drain("odd_line_done");

      // vsync cuts a line after 3 bytes
      send_rand(3, 1'b1, 3);
      drain("vsync_abort_done");
      send_rand(6, 1'b1, 2);

      // start of frame
      vsync_pulse(10);
      send_rand(6, 1'b0, 2);
      send_rand(4, 1'b0, 2);
      drain("sof_done");

      // random lines, gaps, aborts and frame pulses
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 5) == 0) vsync_pulse($urandom_range(1, 8));
         send_rand($urandom_range(1, 12), ($urandom_range(0, 7) == 0), $urandom_range(1, 4));
      end
      drain("random_done");

      // reset in the middle of a line
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      tick(); din = r0; href = 1'b1;
      tick(); din = r1;
      for (int i = 0; i < 3; i++) begin
         tick(); din = 8'($urandom);
      end
      chk_en = 1'b0;
      chk("pre_rst_tvalid", 32'(bus.m_tvalid), 1);
      chk("pre_rst_tdata",  32'(bus.m_tdata), {16'h0, r0, r1});
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tvalid", 32'(bus.m_tvalid), 0);
      chk("async_rst_tdata",  32'(bus.m_tdata), 0);
      chk("async_rst_tlast",  32'(bus.m_tlast), 0);
      chk("async_rst_tuser",  32'(tuser_obs), 0);
      for (int i = 0; i < 3; i++) begin
         tick(); din = 8'($urandom);
      end
      rst_n  = 1'b1;
      sof_m  = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); din = 8'($urandom); href = 1'b1;
      end
      idle(2);
      send_rand(6, 1'b0, 2);
      send_rand(5, 1'b0, 2);
      drain("after_reset_done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
